uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate in bit/s.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, number of stop bits (1 or 2).
REQ-005 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 Port rst  input  1  reset; asynchronous, active-low.
REQ-007 Port data  input  8  byte to transmit, sampled only on acceptance.
REQ-008 Port valid  input  1  data valid request from the upstream block.
REQ-009 Port ready  output  1  block can accept a byte this cycle.
REQ-010 Port tx  output  1  serial line, idle high, registered.
REQ-011 Port busy  output  1  frame in progress (any state other than IDLE).

Function
REQ-012 Bit period N SHALL be CLK_FREQ/BAUD_RATE, integer-truncated (5208 at defaults); the baud counter SHALL be 16 bits wide and count 0..N-1.
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-014 Acceptance SHALL occur on a rising edge where valid=1 and ready=1; ready SHALL be 1 only in IDLE.
REQ-015 On acceptance the block SHALL latch data into a shift register, clear the baud counter and bit index, enter START, and drop ready and raise busy on the same edge.
REQ-016 tx SHALL go low on the acceptance edge and hold each bit for exactly N cycles.
REQ-017 START lasts N cycles; DATA SHALL then send 8 bits LSB first, N cycles each.
REQ-018 PARITY SHALL send XOR of the latched byte (even) or its inverse (odd) for N cycles.
REQ-019 STOP SHALL drive tx=1 for STOP_BITS*N cycles, then enter IDLE with ready=1 and busy=0.
REQ-020 Frame length SHALL be (10 + (PARITY!=0) + (STOP_BITS-1))*N cycles from the acceptance edge to the IDLE entry edge.
REQ-021 Back-to-back: valid held high in IDLE SHALL be accepted on the first IDLE cycle, so each frame after the first starts one clock after the previous frame ends.
REQ-022 Changes on data or valid while busy=1 SHALL have no effect on the frame in progress.
REQ-023 valid=0 in IDLE SHALL keep tx=1 indefinitely, with the counter held at 0.
REQ-024 Bit transitions SHALL occur only when the counter reaches N-1, which wraps it to 0 on the same edge.

Reset
REQ-025 While rst=0: tx=1, ready=0, busy=0, state=IDLE, counter=0, bit index=0, shift register=0.
REQ-026 Assertion mid-frame SHALL abort the frame immediately (asynchronously); no partial frame SHALL resume.
REQ-027 ready SHALL rise on the first rising edge after rst deasserts.

Structure
REQ-028 Package uart_pkg SHALL hold the state encoding, the parity-mode constants and a function computing N; uart_rx SHALL share this package.
REQ-029 Baud timing SHALL be a sub-module uart_baud_gen (clear input, tick output) that uart_rx can reuse.

Verification (bench override: CLK_FREQ=1600, BAUD_RATE=100, so N=16)
REQ-030 Send 0x55 with PARITY=0, STOP_BITS=1 -> tx 0,1,0,1,0,1,0,1,0,1, 16 cycles each; ready returns after 160 cycles.
REQ-031 Send 0xA3 with PARITY=1, then with PARITY=2 -> data bits 1,1,0,0,0,1,0,1, then parity bit 0 (even) and 1 (odd); frame length 176 cycles.
REQ-032 Send 0x00 with STOP_BITS=2 -> 9 low bit periods, then tx high for 32 cycles; total 192 cycles.
REQ-033 Hold valid high with 0x12 then 0x34 -> two frames separated by exactly one idle-high cycle; data changed mid-frame does not corrupt the first frame.
REQ-034 Assert rst at cycle 70 of a 0xFF frame -> tx=1 and busy=0 immediately; after release, ready=1 one edge later and the next byte transmits correctly.
REQ-035 valid=0 for 1000 cycles after reset -> tx constant 1, ready constant 1, busy constant 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes and bit-period helpers.
// Used by uart_tx and uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // Clocks per bit, integer-truncated.
  function automatic int unsigned bit_period(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic logic parity_bit(input logic [7:0] b, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~^b : ^b;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..PERIOD-1 while not cleared, pulses tick on the last count.
// Shared by uart_tx and uart_rx.
module uart_baud_gen #(
  parameter int unsigned PERIOD = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PERIOD - 1);

  logic [15:0] cnt;

  assign tick = !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, 1 or 2 stop bits.
// tx, ready and busy are all registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned N = bit_period(CLK_FREQ, BAUD_RATE);

  uart_state_t state;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        par_bit;
  logic        clear;
  logic        tick;

  // Counter is held at zero in IDLE, so the acceptance edge also restarts timing.
  assign clear = (state == ST_IDLE);

  uart_baud_gen #(
    .PERIOD(N)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      ready   <= 1'b0;
      busy    <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
      par_bit <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid && ready) begin
            shreg   <= data;
            par_bit <= parity_bit(data, PARITY);
            bit_idx <= '0;
            state   <= ST_START;
            tx      <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end else begin
            tx    <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            state <= ST_DATA;
            tx    <= shreg[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY != PARITY_NONE) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              // Shift so the next bit is always at shreg[0] after this edge.
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state   <= ST_STOP;
            tx      <= 1'b1;
            bit_idx <= '0;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (bit_idx == 3'(STOP_BITS - 1)) begin
              state <= ST_IDLE;
              ready <= 1'b1;
              busy  <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at N=16 clocks per bit; four instances cover the parity
// and stop-bit variants, with a per-cycle scoreboard of expected tx/ready/busy.
module tb_uart_tx;

  localparam int NB = 16;

  logic       clk;
  logic       rst_n;
  logic [3:0] valid_v;
  logic [7:0] data_v [4];
  logic [3:0] tx_v;
  logic [3:0] ready_v;
  logic [3:0] busy_v;

  typedef struct packed {
    logic tx;
    logic rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_bad;

  uart_tx #(.CLK_FREQ(1600), .BAUD_RATE(100), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst_n), .data(data_v[0]), .valid(valid_v[0]),
    .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));
  uart_tx #(.CLK_FREQ(1600), .BAUD_RATE(100), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst_n), .data(data_v[1]), .valid(valid_v[1]),
    .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));
  uart_tx #(.CLK_FREQ(1600), .BAUD_RATE(100), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst_n), .data(data_v[2]), .valid(valid_v[2]),
    .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]));
  uart_tx #(.CLK_FREQ(1600), .BAUD_RATE(100), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst_n), .data(data_v[3]), .valid(valid_v[3]),
    .ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Expected line waveform for one frame, one entry per clock after the acceptance edge.
  task automatic push_frame(input logic [7:0] b, input int par, input int nstop);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (par == 1) bits.push_back(b[0]^b[1]^b[2]^b[3]^b[4]^b[5]^b[6]^b[7]);
    if (par == 2) bits.push_back(~(b[0]^b[1]^b[2]^b[3]^b[4]^b[5]^b[6]^b[7]));
    for (int i = 0; i < nstop; i++) bits.push_back(1'b1);
    foreach (bits[k])
      for (int c = 0; c < NB; c++) exp_q.push_back('{tx: bits[k], rdy: 1'b0});
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{tx: 1'b1, rdy: 1'b1});
  endtask

  // Compare n scoreboard entries against instance idx, advancing one clock after each.
  task automatic drain(input int idx, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underrun", 1'b1, 1'b0);
        return;
      end
      e = exp_q.pop_front();
      chk("tx", tx_v[idx], e.tx);
      chk("ready", ready_v[idx], e.rdy);
      chk("busy", busy_v[idx], ~e.rdy);
      tick();
    end
  endtask

  task automatic send(input int idx, input logic [7:0] b, input int par, input int nstop);
    chk("ready_before_send", ready_v[idx], 1'b1);
    data_v[idx]  = b;
    valid_v[idx] = 1'b1;
    tick();
    valid_v[idx] = 1'b0;
    data_v[idx]  = ~b;
    push_frame(b, par, nstop);
    push_idle(1);
    drain(idx, exp_q.size());
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    valid_v = '0;
    for (int i = 0; i < 4; i++) data_v[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_tx", tx_v[i], 1'b1);
      chk("rst_ready", ready_v[i], 1'b0);
      chk("rst_busy", busy_v[i], 1'b0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_first_edge", ready_v[0], 1'b0);
    tick();
    for (int i = 0; i < 4; i++) chk("ready_first_edge", ready_v[i], 1'b1);

    // Long idle with valid low
    push_idle(1000);
    drain(0, 1000);

    send(0, 8'h55, 0, 1);
    send(1, 8'hA3, 1, 1);
    send(2, 8'hA3, 2, 1);
    send(3, 8'h00, 0, 2);

    // Back-to-back with valid held high; data changes while the first frame is in flight
    data_v[0]  = 8'h12;
    valid_v[0] = 1'b1;
    tick();
    push_frame(8'h12, 0, 1);
    push_idle(1);
    push_frame(8'h34, 0, 1);
    push_idle(1);
    drain(0, 80);
    data_v[0] = 8'h34;
    drain(0, 161);
    valid_v[0] = 1'b0;
    drain(0, exp_q.size());

    // Reset 70 clocks into a 0xFF frame
    data_v[0]  = 8'hFF;
    valid_v[0] = 1'b1;
    tick();
    valid_v[0] = 1'b0;
    push_frame(8'hFF, 0, 1);
    drain(0, 70);
    exp_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_tx", tx_v[0], 1'b1);
    chk("abort_busy", busy_v[0], 1'b0);
    chk("abort_ready", ready_v[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_low_after_release", ready_v[0], 1'b0);
    tick();
    chk("ready_after_release", ready_v[0], 1'b1);
    chk("busy_after_release", busy_v[0], 1'b0);
    chk("tx_after_release", tx_v[0], 1'b1);
    send(0, 8'hC6, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
